// File: rtl/pong_pkg.sv
// Shared pong constants: screen limits, colours, paddle geometry and the
// ball stepper state type.
package pong_pkg;

    localparam logic [7:0] X_MAX     = 8'd159;
    localparam logic [6:0] Y_MAX     = 7'd119;
    localparam logic [7:0] X_START   = 8'd80;
    localparam logic [6:0] Y_START   = 7'd60;
    localparam logic [7:0] PADDLE1_X = 8'd2;
    localparam logic [7:0] PADDLE2_X = 8'd157;
    localparam int         PADDLE_LEN = 12;

    localparam logic [2:0] BALL_COLOR = 3'b111;
    localparam logic [2:0] BG_COLOR   = 3'b000;

    // HOLD_CYCLES must cover the output-mux sampling period of 4 clocks.
    localparam int HOLD_CYCLES     = 4;
    localparam int FRAMES_PER_STEP = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        UPDATE = 2'd2,
        DRAW   = 2'd3
    } ball_state_t;

endpackage

// File: rtl/ball_move_if.sv
// Control and pixel-stream bundle between the ball stepper and the rest of
// the pong game.
interface ball_move_if;
    logic       frame_tick;
    logic       enable;
    logic [6:0] paddle1y;
    logic [6:0] paddle2y;
    logic [7:0] x_out_b;
    logic [6:0] y_out_b;
    logic [2:0] color_out_b;
    logic       busy;
    logic       score_p1;
    logic       score_p2;

    modport master (
        input  frame_tick, enable, paddle1y, paddle2y,
        output x_out_b, y_out_b, color_out_b, busy, score_p1, score_p2
    );

    modport slave (
        output frame_tick, enable, paddle1y, paddle2y,
        input  x_out_b, y_out_b, color_out_b, busy, score_p1, score_p2
    );
endinterface

// File: rtl/ball_collide.sv
// Next-position logic for one ball step: wall bounce, paddle hit and score.
// Purely combinational; direction bits are 1 for +1 and 0 for -1.
module ball_collide
    import pong_pkg::*;
(
    input  logic [7:0] bx,
    input  logic [6:0] by,
    input  logic       dx_pos,
    input  logic       dy_pos,
    input  logic [6:0] paddle1y,
    input  logic [6:0] paddle2y,
    output logic [7:0] next_bx,
    output logic [6:0] next_by,
    output logic       next_dx_pos,
    output logic       next_dy_pos,
    output logic       score_p1,
    output logic       score_p2
);

    logic [7:0] by_w;
    logic [7:0] p1_lo, p1_hi, p2_lo, p2_hi;
    logic       in_p1, in_p2;

    // Span bounds widened to 8 bits so paddle rows near the bottom cannot wrap.
    assign by_w  = {1'b0, by};
    assign p1_lo = {1'b0, paddle1y};
    assign p2_lo = {1'b0, paddle2y};
    assign p1_hi = p1_lo + 8'(PADDLE_LEN - 1);
    assign p2_hi = p2_lo + 8'(PADDLE_LEN - 1);
    assign in_p1 = (by_w >= p1_lo) && (by_w <= p1_hi);
    assign in_p2 = (by_w >= p2_lo) && (by_w <= p2_hi);

    always_comb begin
        next_bx     = bx;
        next_by     = by;
        next_dx_pos = dx_pos;
        next_dy_pos = dy_pos;
        score_p1    = 1'b0;
        score_p2    = 1'b0;

        if (dy_pos && by == Y_MAX) begin
            next_dy_pos = 1'b0;
            next_by     = Y_MAX - 7'd1;
        end else if (!dy_pos && by == 7'd0) begin
            next_dy_pos = 1'b1;
            next_by     = 7'd1;
        end else if (dy_pos) begin
            next_by = by + 7'd1;
        end else begin
            next_by = by - 7'd1;
        end

        if (dx_pos && bx == PADDLE2_X - 8'd1 && in_p2) begin
            next_dx_pos = 1'b0;
            next_bx     = bx - 8'd1;
        end else if (!dx_pos && bx == PADDLE1_X + 8'd1 && in_p1) begin
            next_dx_pos = 1'b1;
            next_bx     = bx + 8'd1;
        end else if (dx_pos && bx == X_MAX) begin
            score_p1 = 1'b1;
        end else if (!dx_pos && bx == 8'd0) begin
            score_p2 = 1'b1;
        end else if (dx_pos) begin
            next_bx = bx + 8'd1;
        end else begin
            next_bx = bx - 8'd1;
        end

        // A serve overrides both axes; vertical direction is kept as it was.
        if (score_p1 || score_p2) begin
            next_bx     = X_START;
            next_by     = Y_START;
            next_dx_pos = score_p1;
            next_dy_pos = dy_pos;
        end
    end

endmodule

// File: rtl/ball_move.sv
// Ball stepper: every FRAMES_PER_STEP frames erase the ball pixel, move it,
// then redraw it, holding each pixel long enough for the output mux.
module ball_move
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset_co,
    ball_move_if.master bus
);

    localparam int FCNT_W = $clog2(FRAMES_PER_STEP);
    localparam int HCNT_W = $clog2(HOLD_CYCLES);

    ball_state_t       state;
    logic [7:0]        bx;
    logic [6:0]        by;
    logic              dx_pos;
    logic              dy_pos;
    logic [FCNT_W-1:0] fcnt;
    logic [HCNT_W-1:0] hcnt;

    logic [7:0] next_bx;
    logic [6:0] next_by;
    logic       next_dx_pos;
    logic       next_dy_pos;
    logic       hit_score_p1;
    logic       hit_score_p2;

    ball_collide u_collide (
        .bx          (bx),
        .by          (by),
        .dx_pos      (dx_pos),
        .dy_pos      (dy_pos),
        .paddle1y    (bus.paddle1y),
        .paddle2y    (bus.paddle2y),
        .next_bx     (next_bx),
        .next_by     (next_by),
        .next_dx_pos (next_dx_pos),
        .next_dy_pos (next_dy_pos),
        .score_p1    (hit_score_p1),
        .score_p2    (hit_score_p2)
    );

    always_ff @(posedge clk or negedge reset_co) begin
        if (!reset_co) begin
            state           <= IDLE;
            bx              <= X_START;
            by              <= Y_START;
            dx_pos          <= 1'b1;
            dy_pos          <= 1'b1;
            fcnt            <= '0;
            hcnt            <= '0;
            bus.x_out_b     <= X_START;
            bus.y_out_b     <= Y_START;
            bus.color_out_b <= BALL_COLOR;
            bus.busy        <= 1'b0;
            bus.score_p1    <= 1'b0;
            bus.score_p2    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.frame_tick && bus.enable) begin
                        if (fcnt == FCNT_W'(FRAMES_PER_STEP - 1)) begin
                            fcnt            <= '0;
                            state           <= ERASE;
                            bus.busy        <= 1'b1;
                            bus.color_out_b <= BG_COLOR;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                ERASE: begin
                    if (hcnt == HCNT_W'(HOLD_CYCLES - 1)) begin
                        hcnt  <= '0;
                        state <= UPDATE;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                UPDATE: begin
                    bx              <= next_bx;
                    by              <= next_by;
                    dx_pos          <= next_dx_pos;
                    dy_pos          <= next_dy_pos;
                    bus.x_out_b     <= next_bx;
                    bus.y_out_b     <= next_by;
                    bus.color_out_b <= BALL_COLOR;
                    bus.score_p1    <= hit_score_p1;
                    bus.score_p2    <= hit_score_p2;
                    state           <= DRAW;
                end
                DRAW: begin
                    bus.score_p1 <= 1'b0;
                    bus.score_p2 <= 1'b0;
                    if (hcnt == HCNT_W'(HOLD_CYCLES - 1)) begin
                        hcnt     <= '0;
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_move.sv
// Self-checking bench for ball_move: directed scenarios plus randomized
// paddles, compared against an integer model of the ball rules.
module tb_ball_move;

    localparam int XMAX = 159, YMAX = 119, XS = 80, YS = 60;
    localparam int P1X = 2, P2X = 157, PLEN = 12;

    logic clk = 1'b0;
    logic reset_co = 1'b0;
    always #5 clk = ~clk;

    ball_move_if bif ();

    ball_move dut (
        .clk      (clk),
        .reset_co (reset_co),
        .bus      (bif)
    );

    int checks = 0;
    int passes = 0;
    int mx, my, mvx, mvy;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic checkPixel(input string tag, input int x, input int y, input int c);
        check({tag, "_x"}, 32'(bif.x_out_b), 32'(x));
        check({tag, "_y"}, 32'(bif.y_out_b), 32'(y));
        check({tag, "_color"}, 32'(bif.color_out_b), 32'(c));
    endtask

    task automatic checkReset(input string tag);
        checkPixel(tag, XS, YS, 7);
        check({tag, "_busy"}, 32'(bif.busy), 0);
        check({tag, "_score_p1"}, 32'(bif.score_p1), 0);
        check({tag, "_score_p2"}, 32'(bif.score_p2), 0);
    endtask

    function automatic void modelReset();
        mx = XS; my = YS; mvx = 1; mvy = 1;
    endfunction

    // Ball rules in plain integer form; velocities are +1 / -1.
    function automatic void modelAdvance(input int p1, input int p2, output bit s1, output bit s2);
        int nx, ny, nvx, nvy;
        s1 = 0; s2 = 0;
        nvx = mvx; nvy = mvy;
        nx = mx + mvx;
        if (mvx > 0 && mx == P2X - 1 && my >= p2 && my <= p2 + PLEN - 1) begin
            nvx = -1; nx = mx - 1;
        end else if (mvx < 0 && mx == P1X + 1 && my >= p1 && my <= p1 + PLEN - 1) begin
            nvx = 1; nx = mx + 1;
        end else if (mvx > 0 && mx == XMAX) begin
            s1 = 1;
        end else if (mvx < 0 && mx == 0) begin
            s2 = 1;
        end
        if (mvy > 0 && my == YMAX) begin
            nvy = -1; ny = YMAX - 1;
        end else if (mvy < 0 && my == 0) begin
            nvy = 1; ny = 1;
        end else begin
            ny = my + mvy;
        end
        if (s1 || s2) begin
            nx = XS; ny = YS; nvx = s1 ? 1 : -1; nvy = mvy;
        end
        mx = nx; my = ny; mvx = nvx; mvy = nvy;
    endfunction

    task automatic doReset();
        reset_co = 1'b0;
        bif.frame_tick = 1'b0;
        nextCycle();
        nextCycle();
        checkReset("reset");
        reset_co = 1'b1;
        nextCycle();
        modelReset();
    endtask

    // Issue nTicks frame ticks, then follow one full erase/update/draw step.
    task automatic runStep(input int nTicks, input bit ticksInBusy, input bit resetInDraw);
        int ox, oy, nx, ny;
        bit s1, s2;
        ox = mx; oy = my;
        modelAdvance(int'(bif.paddle1y), int'(bif.paddle2y), s1, s2);
        nx = mx; ny = my;
        for (int k = 0; k < nTicks; k++) begin
            bif.frame_tick = 1'b1;
            nextCycle();
            bif.frame_tick = 1'b0;
            if (k < nTicks - 1) begin
                check("wait_busy", 32'(bif.busy), 0);
                checkPixel("wait", ox, oy, 7);
                repeat ($urandom_range(0, 2)) nextCycle();
            end
        end
        for (int c = 1; c <= 9; c++) begin
            check("step_busy", 32'(bif.busy), 1);
            if (c <= 5) checkPixel("erase", ox, oy, 0);
            else checkPixel("draw", nx, ny, 7);
            check("step_score_p1", 32'(bif.score_p1), 32'(c == 6 && s1));
            check("step_score_p2", 32'(bif.score_p2), 32'(c == 6 && s2));
            if (resetInDraw && c == 7) begin
                bif.frame_tick = 1'b0;
                #2 reset_co = 1'b0;
                #1;
                checkReset("async_reset");
                modelReset();
                return;
            end
            bif.frame_tick = ticksInBusy && (c % 3 == 0);
            nextCycle();
        end
        bif.frame_tick = 1'b0;
        check("end_busy", 32'(bif.busy), 0);
        checkPixel("idle", nx, ny, 7);
        check("end_score_p1", 32'(bif.score_p1), 0);
        check("end_score_p2", 32'(bif.score_p2), 0);
    endtask

    task automatic applyStimulus();
        bif.frame_tick = 1'b0;
        bif.enable = 1'b1;
        bif.paddle1y = 7'd0;
        bif.paddle2y = 7'd0;
        doReset();

        // First step, with ticks thrown in while busy that must be ignored.
        runStep(4, 1, 0);
        checkPixel("step1", 81, 61, 7);
        for (int s = 2; s <= 59; s++) runStep(4, s % 5 == 0, 0);
        checkPixel("step59", 139, 119, 7);
        runStep(4, 0, 0);
        checkPixel("step60", 140, 118, 7);
        bif.paddle2y = 7'd95;
        for (int s = 61; s <= 76; s++) runStep(4, 0, 0);
        checkPixel("step76", 156, 102, 7);
        runStep(4, 0, 0);
        checkPixel("step77_hit", 155, 101, 7);
        runStep(4, 0, 0);
        checkPixel("step78_left", 154, 100, 7);

        // Right-edge miss and serve.
        bif.paddle2y = 7'd0;
        doReset();
        for (int s = 1; s <= 79; s++) runStep(4, 0, 0);
        checkPixel("step79", 159, 99, 7);
        runStep(4, 0, 0);
        checkPixel("step80_serve", 80, 60, 7);

        // Disabled ticks must neither start a step nor advance the count.
        for (int k = 0; k < 2; k++) begin
            bif.frame_tick = 1'b1; nextCycle(); bif.frame_tick = 1'b0;
            check("pre_busy", 32'(bif.busy), 0);
        end
        bif.enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bif.frame_tick = 1'b1; nextCycle(); bif.frame_tick = 1'b0;
            check("disabled_busy", 32'(bif.busy), 0);
        end
        bif.enable = 1'b1;
        runStep(2, 0, 0);
        checkPixel("step81", 81, 59, 7);

        // Asynchronous reset in the second draw clock.
        runStep(4, 0, 1);
        nextCycle();
        reset_co = 1'b1;
        nextCycle();
        runStep(4, 0, 0);
        checkPixel("after_reset", 81, 61, 7);

        // Randomized paddles exercise both paddles, both edges and corners.
        doReset();
        for (int s = 0; s < 300; s++) begin
            bif.paddle1y = 7'($urandom_range(0, 127));
            bif.paddle2y = 7'($urandom_range(0, 127));
            runStep(4, $urandom_range(0, 1) == 1, 0);
        end
    endtask

    task automatic checkOutput();
        $display("[TB] %0d/%0d checks passed", passes, checks);
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

endmodule
